payload_char_feeder: RTL and testbench

- Front end that drives the payload regex engines.
- Accepts a byte stream, emits one `eng_sod` clear pulse per packet, then feeds one character per `eng_en` cycle as a one-hot/multi-hot class vector from a programmable 256-entry class table.
- Inserts beginning-of-line (BOL) pseudo-characters for `^` anchors: at payload start and, in multiline mode, after each newline.
- After end of packet, waits for the engine pipeline to settle, samples the engine match vector and reports a per-packet result.

---
 rtl/payload_char_feeder.sv | 196 +++++++++++++++++++
 tb/tb_payload_char_feeder.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/payload_char_feeder.sv
// payload_char_feeder: front end for the payload regex engines.
// Takes a byte stream, clears the engines once per packet, inserts
// beginning-of-line pseudo-characters, and translates each accepted byte
// into a class vector through a programmable 256-entry table. After the
// last byte it lets the engine pipeline settle, then reports the sampled
// match vector together with the packet length.
//
// Timing model: every eng_* and res_* output is a register driven from the
// current FSM state. What a state "does" therefore shows up on the outputs
// one cycle after the FSM sits in that state. For example, the BOL that
// follows a newline appears right after the newline character itself.
module payload_char_feeder #(
  parameter int         NUM_CLASS     = 32,
  parameter int         NUM_ENG       = 16,
  parameter int         BOL_CLASS     = 0,
  parameter logic [7:0] NL_BYTE       = 8'h0A,
  parameter bit         INSERT_NL_BOL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  input  logic                 s_sop,
  input  logic                 s_eop,
  output logic                 s_ready,
  input  logic                 cfg_we,
  input  logic [7:0]           cfg_addr,
  input  logic [NUM_CLASS-1:0] cfg_data,
  output logic                 eng_sod,
  output logic                 eng_en,
  output logic [NUM_CLASS-1:0] eng_char,
  input  logic [NUM_ENG-1:0]   eng_match,
  output logic                 res_valid,
  output logic [NUM_ENG-1:0]   res_match,
  output logic [15:0]          res_len,
  output logic [15:0]          drop_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    SOD,
    BOL,
    STREAM,
    NLBOL,
    DRAIN,
    RESULT
  } state_t;

  // Class vector for a BOL pseudo-character: only the BOL class bit is set.
  localparam logic [NUM_CLASS-1:0] BOL_VEC = {{(NUM_CLASS-1){1'b0}}, 1'b1} << BOL_CLASS;

  state_t               state;
  state_t               state_next;
  logic [NUM_CLASS-1:0] class_table [256];
  logic [15:0]          len_cnt;
  logic                 drain_cnt;
  logic                 stream_hs;
  logic                 stray_hs;
  logic                 bol_slot;

  // A byte is consumed in STREAM whenever it is valid, because s_ready is
  // constantly high there. In IDLE, any valid byte without sop is swallowed.
  assign stream_hs = (state == STREAM) && s_valid;
  assign stray_hs  = (state == IDLE) && s_valid && !s_sop;
  assign bol_slot  = (state == BOL) || (state == NLBOL);

  // Next-state and ready logic. The sop byte is left waiting in IDLE, and
  // STREAM accepts it after the clear and BOL slots have gone out.
  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    case (state)
      IDLE: begin
        s_ready = s_valid && !s_sop;
        if (s_valid && s_sop) begin
          state_next = SOD;
        end
      end
      SOD: begin
        state_next = BOL;
      end
      BOL, NLBOL: begin
        state_next = STREAM;
      end
      STREAM: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (s_eop) begin
            state_next = DRAIN;
          end else if (INSERT_NL_BOL && (s_data == NL_BYTE)) begin
            state_next = NLBOL;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt) begin
          state_next = RESULT;
        end
      end
      RESULT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Two-cycle drain timer. It toggles only while in DRAIN, so it always
  // enters DRAIN at zero and leaves after its second cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt <= 1'b0;
    end else if (state == DRAIN) begin
      drain_cnt <= !drain_cnt;
    end else begin
      drain_cnt <= 1'b0;
    end
  end

  // Class table. It is cleared on reset, and a write becomes visible to
  // lookups on the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) begin
        class_table[i] <= '0;
      end
    end else if (cfg_we) begin
      class_table[cfg_addr] <= cfg_data;
    end
  end

  // Per-packet byte count. It restarts at the engine clear and saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_cnt <= '0;
    end else if (state == SOD) begin
      len_cnt <= '0;
    end else if (stream_hs && (len_cnt != 16'hFFFF)) begin
      len_cnt <= len_cnt + 16'd1;
    end
  end

  // Engine drive. eng_char only changes when a character is issued, so the
  // engines see a stable vector while eng_en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      eng_sod  <= 1'b0;
      eng_en   <= 1'b0;
      eng_char <= '0;
    end else begin
      eng_sod <= (state == SOD);
      eng_en  <= bol_slot || stream_hs;
      if (bol_slot) begin
        eng_char <= BOL_VEC;
      end else if (stream_hs) begin
        eng_char <= class_table[s_data];
      end
    end
  end

  // Result capture. The match vector and length hold until the next packet
  // completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_match <= '0;
      res_len   <= '0;
    end else begin
      res_valid <= (state == RESULT);
      if (state == RESULT) begin
        res_match <= eng_match;
        res_len   <= len_cnt;
      end
    end
  end

  // Saturating count of stray bytes discarded while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (stray_hs && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_payload_char_feeder.sv
// Directed testbench for payload_char_feeder, with a small sticky-match
// engine model hooked to the engine interface.
module tb_payload_char_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_sop = 1'b0;
  logic        s_eop = 1'b0;
  logic        s_ready;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_addr = '0;
  logic [31:0] cfg_data = '0;
  logic        eng_sod;
  logic        eng_en;
  logic [31:0] eng_char;
  logic [15:0] eng_match;
  logic        res_valid;
  logic [15:0] res_match;
  logic [15:0] res_len;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] en_q[$];
  int          en_cyc[$];
  int          hs_cyc[$];
  bit          rdy_at[int];
  int          sod_cnt = 0;
  int          rv_cnt = 0;
  int          rv_cyc = -1;

  logic st_e, st_x, st_bol_e, prev_bol;

  localparam logic [31:0] C_E  = 32'h0002_0000;
  localparam logic [31:0] C_X  = 32'h0400_0000;
  localparam logic [31:0] C_P  = 32'h0020_0000;
  localparam logic [31:0] C_N  = 32'h0000_0008;
  localparam logic [31:0] C_SP = 32'h0000_0002;
  localparam logic [31:0] C_A  = 32'h0000_0020;
  localparam logic [31:0] C_NL = 32'h0000_0200;
  localparam logic [31:0] C_B  = 32'h0000_0040;
  localparam logic [31:0] C_BOL = 32'h0000_0001;

  payload_char_feeder dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_sop     (s_sop),
    .s_eop     (s_eop),
    .s_ready   (s_ready),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .eng_sod   (eng_sod),
    .eng_en    (eng_en),
    .eng_char  (eng_char),
    .eng_match (eng_match),
    .res_valid (res_valid),
    .res_match (res_match),
    .res_len   (res_len),
    .drop_cnt  (drop_cnt)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Engine model. Bit0 is set by any 'e', bit1 by any 'x', and bit2 by a
  // BOL immediately followed by 'e'. Its state flop plus its registered
  // output give two cycles of pipeline delay.
  always @(posedge clk) begin
    if (rst || eng_sod) begin
      st_e <= 1'b0; st_x <= 1'b0; st_bol_e <= 1'b0; prev_bol <= 1'b0;
    end else if (eng_en) begin
      if (eng_char[17]) st_e <= 1'b1;
      if (eng_char[26]) st_x <= 1'b1;
      if (prev_bol && eng_char[17]) st_bol_e <= 1'b1;
      prev_bol <= eng_char[0];
    end
    if (rst) eng_match <= '0;
    else eng_match <= {13'b0, st_bol_e, st_x, st_e};
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (eng_en) begin
      en_q.push_back(eng_char);
      en_cyc.push_back(cyc);
    end
    if (eng_sod) sod_cnt++;
    if (res_valid) begin
      rv_cnt++;
      rv_cyc = cyc;
    end
  end

  task automatic clear_mon();
    en_q.delete(); en_cyc.delete(); hs_cyc.delete(); rdy_at.delete();
    sod_cnt = 0; rv_cnt = 0; rv_cyc = -1;
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic program_table();
    cfg_write(8'h65, C_E);  cfg_write(8'h45, C_E);
    cfg_write(8'h78, C_X);  cfg_write(8'h58, C_X);
    cfg_write(8'h70, C_P);  cfg_write(8'h50, C_P);
    cfg_write(8'h6E, C_N);  cfg_write(8'h4E, C_N);
    cfg_write(8'h20, C_SP); cfg_write(8'h09, C_SP);
    cfg_write(8'h61, C_A);  cfg_write(8'h0A, C_NL);
    cfg_write(8'h62, C_B);
  endtask

  task automatic send_str(input string s, input bit throttle, input bit with_eop);
    int  i = 0;
    int  guard = 0;
    bit  phase = 1'b0;
    bit  hs;
    while (i < s.len() && guard < 200) begin
      guard++;
      s_valid = !(throttle && phase);
      s_data  = s[i];
      s_sop   = (i == 0);
      s_eop   = with_eop && (i == s.len() - 1);
      @(negedge clk);
      rdy_at[cyc] = s_ready;
      hs = s_valid && s_ready;
      if (hs) hs_cyc.push_back(cyc);
      @(posedge clk); #1;
      if (hs) i++;
      phase = !phase;
    end
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
    checks++;
    if (i != s.len()) begin
      errors++;
      $display("[TB] FAIL send_timeout: sent %0d bytes, required %0d", i, s.len());
    end
  endtask

  task automatic wait_result(input string name);
    int n = 0;
    while (rv_cnt == 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rv_cnt == 0) begin
      errors++;
      $display("[TB] FAIL %s_timeout: res_valid not seen, required within 40 cycles", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({eng_sod, eng_en, res_valid, s_ready} !== 4'b0) begin
      errors++;
      $display("[TB] FAIL reset_strobes: got %b required 0000", {eng_sod, eng_en, res_valid, s_ready});
    end
    checks++;
    if (eng_char !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_char: got %h required 0", eng_char);
    end
    checks++;
    if ({res_match, res_len, drop_cnt} !== 48'h0) begin
      errors++;
      $display("[TB] FAIL reset_regs: got %h required 0", {res_match, res_len, drop_cnt});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] exp_c[7];
    exp_c = '{C_BOL, C_E, C_X, C_P, C_N, C_SP, C_E};
    clear_mon();
    send_str("expn e", 1'b0, 1'b1);
    wait_result("basic");
    checks++;
    if (sod_cnt !== 1) begin
      errors++;
      $display("[TB] FAIL basic_sod: got %0d pulses required 1", sod_cnt);
    end
    checks++;
    if (en_q.size() !== 7) begin
      errors++;
      $display("[TB] FAIL basic_en_count: got %0d required 7", en_q.size());
    end
    for (int k = 0; k < 7 && k < en_q.size(); k++) begin
      checks++;
      if (en_q[k] !== exp_c[k]) begin
        errors++;
        $display("[TB] FAIL basic_char%0d: got %h required %h", k, en_q[k], exp_c[k]);
      end
    end
    checks++;
    if (res_len !== 16'd6) begin
      errors++;
      $display("[TB] FAIL basic_len: got %0d required 6", res_len);
    end
    checks++;
    if (res_match !== 16'h0007) begin
      errors++;
      $display("[TB] FAIL basic_match: got %h required 0007", res_match);
    end
    checks++;
    if (hs_cyc.size() != 6 || rv_cyc != hs_cyc[5] + 4) begin
      errors++;
      $display("[TB] FAIL basic_latency: res_valid at %0d required eop+4 (%0d hs)", rv_cyc, hs_cyc.size());
    end
    checks++;
    if (rv_cnt !== 1) begin
      errors++;
      $display("[TB] FAIL basic_rv_pulses: got %0d required 1", rv_cnt);
    end
  endtask

  task automatic test_newline();
    logic [31:0] exp_c[5];
    int nl;
    exp_c = '{C_BOL, C_A, C_NL, C_BOL, C_B};
    clear_mon();
    send_str("a\nb", 1'b0, 1'b1);
    wait_result("newline");
    checks++;
    if (en_q.size() !== 5) begin
      errors++;
      $display("[TB] FAIL nl_en_count: got %0d required 5", en_q.size());
    end
    for (int k = 0; k < 5 && k < en_q.size(); k++) begin
      checks++;
      if (en_q[k] !== exp_c[k]) begin
        errors++;
        $display("[TB] FAIL nl_char%0d: got %h required %h", k, en_q[k], exp_c[k]);
      end
    end
    nl = (hs_cyc.size() > 1) ? hs_cyc[1] : -10;
    checks++;
    if ((rdy_at.exists(nl + 1) ? rdy_at[nl + 1] : 1'b1) !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nl_ready_gap: s_ready after newline not 0 at cycle %0d", nl + 1);
    end
    checks++;
    if (res_len !== 16'd3) begin
      errors++;
      $display("[TB] FAIL nl_len: got %0d required 3", res_len);
    end
    checks++;
    if (res_match !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL nl_match: got %h required 0000", res_match);
    end
  endtask

  task automatic test_throttled();
    logic [31:0] exp_c[7];
    exp_c = '{C_BOL, C_E, C_X, C_P, C_N, C_SP, C_E};
    clear_mon();
    send_str("EXPN E", 1'b1, 1'b1);
    wait_result("throttle");
    checks++;
    if (en_q.size() !== 7 || hs_cyc.size() !== 6) begin
      errors++;
      $display("[TB] FAIL thr_count: en %0d hs %0d required 7 and 6", en_q.size(), hs_cyc.size());
    end
    for (int k = 1; k < 7 && k < en_q.size() && k <= hs_cyc.size(); k++) begin
      checks++;
      if (en_cyc[k] !== hs_cyc[k-1] + 1 || en_q[k] !== exp_c[k]) begin
        errors++;
        $display("[TB] FAIL thr_char%0d: got %h at %0d required %h at %0d", k, en_q[k], en_cyc[k], exp_c[k], hs_cyc[k-1] + 1);
      end
    end
    checks++;
    if (res_match !== 16'h0007 || res_len !== 16'd6) begin
      errors++;
      $display("[TB] FAIL thr_result: got match %h len %0d required 0007 and 6", res_match, res_len);
    end
  endtask

  task automatic test_drop();
    logic [7:0] strays[2];
    strays = '{8'h41, 8'h42};
    clear_mon();
    for (int k = 0; k < 2; k++) begin
      s_valid = 1'b1; s_sop = 1'b0; s_eop = 1'b0; s_data = strays[k];
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL drop_ready%0d: got %b required 1", k, s_ready);
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (drop_cnt !== 16'd2) begin
      errors++;
      $display("[TB] FAIL drop_cnt: got %0d required 2", drop_cnt);
    end
    checks++;
    if (sod_cnt !== 0 || en_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL drop_no_sod: got sod %0d en %0d required 0 and 0", sod_cnt, en_q.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    send_str("exp", 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({eng_sod, eng_en, res_valid} !== 3'b0 || eng_char !== 32'h0) begin
      errors++;
      $display("[TB] FAIL rstmid_eng: got sod %b en %b rv %b char %h required all 0", eng_sod, eng_en, res_valid, eng_char);
    end
    checks++;
    if ({res_match, res_len, drop_cnt} !== 48'h0) begin
      errors++;
      $display("[TB] FAIL rstmid_regs: got %h required 0", {res_match, res_len, drop_cnt});
    end
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (rv_cnt !== 0) begin
      errors++;
      $display("[TB] FAIL rstmid_no_result: got %0d res_valid pulses required 0", rv_cnt);
    end
    program_table();
    clear_mon();
    send_str("pe", 1'b0, 1'b1);
    wait_result("rstmid");
    checks++;
    if (sod_cnt !== 1) begin
      errors++;
      $display("[TB] FAIL rstmid_sod: got %0d pulses required 1", sod_cnt);
    end
    checks++;
    if (res_len !== 16'd2 || res_match !== 16'h0001) begin
      errors++;
      $display("[TB] FAIL rstmid_result: got len %0d match %h required 2 and 0001", res_len, res_match);
    end
  endtask

  task automatic test_single();
    clear_mon();
    send_str("\n", 1'b0, 1'b1);
    wait_result("single");
    checks++;
    if (en_q.size() !== 2) begin
      errors++;
      $display("[TB] FAIL single_en_count: got %0d required 2", en_q.size());
    end else begin
      checks++;
      if (en_q[0] !== C_BOL || en_q[1] !== C_NL) begin
        errors++;
        $display("[TB] FAIL single_chars: got %h %h required %h %h", en_q[0], en_q[1], C_BOL, C_NL);
      end
    end
    checks++;
    if (hs_cyc.size() != 1 || rv_cyc != hs_cyc[0] + 4) begin
      errors++;
      $display("[TB] FAIL single_latency: res_valid at %0d required handshake+4", rv_cyc);
    end
    checks++;
    if (res_len !== 16'd1) begin
      errors++;
      $display("[TB] FAIL single_len: got %0d required 1", res_len);
    end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    program_table();
    test_basic();
    test_newline();
    test_throttled();
    test_drop();
    test_reset_mid();
    test_single();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
